alu_control_seq: RTL
====================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port valid, input, 1, instruction presented this cycle.
REQ-004 SHALL have port alu_op, input, 2, main-control class: 00 add, 01 sub, 10 R-type (decode funct), 11 illegal.
REQ-005 SHALL have port funct, input, 6, R-type function field.
REQ-006 SHALL have port alu_sig, output, 3, ALU operation: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-007 SHALL have port mux_sel, output, 2, result source: 00 ALU, 01 shifter, 10 HI, 11 LO.
REQ-008 SHALL have port mult_start, output, 1, one-cycle multiplier start pulse.
REQ-009 SHALL have port hilo_we, output, 1, one-cycle HI/LO write pulse.
REQ-010 SHALL have port stall, output, 1, hold PC/instruction this cycle.
REQ-011 SHALL have port busy, output, 1, multiply sequence in progress.
REQ-012 SHALL have port illegal, output, 1, unsupported encoding presented.

Function
REQ-013 SHALL decode combinationally when valid=1: alu_op 00 -> ADD/ALU; 01 -> SUB/ALU; 10 -> funct 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT (mux 00), 0 shifter (mux 01, alu_sig 010), 16 mfhi (mux 10), 18 mflo (mux 11), 25 multu.
REQ-014 SHALL drive defaults alu_sig=010, mux_sel=00, mult_start=0, stall=0, illegal=0 when valid=0.
REQ-015 SHALL assert illegal=1, with defaults on other decode outputs, for alu_op 11 or an unlisted funct; state unaffected.
REQ-016 SHALL implement states IDLE, MULT, DONE; busy=1 in MULT and DONE.
REQ-017 IDLE: valid multu -> mult_start=1, stall=0 (multu retires), next state MULT, count=0.
REQ-018 MULT: count increments each cycle, 5-bit; at count=31 next state DONE (exactly 32 MULT cycles).
REQ-019 DONE: hilo_we=1 for exactly that cycle, next state IDLE unconditionally.
REQ-020 In MULT or DONE, valid mfhi, mflo or multu SHALL assert stall=1 and suppress mult_start; decode outputs for a stalled instruction are don't-care.
REQ-021 In MULT or DONE, all other valid instructions SHALL decode and proceed with stall=0 (no structural hazard).
REQ-022 Latency: multu accepted in cycle T -> hilo_we in T+33; stalled HI/LO-dependent instruction released (stall=0) in T+34.
REQ-023 illegal and stall SHALL never both be 1.

Reset
REQ-024 rst=1 SHALL force state IDLE, count 0, busy=0, mult_start=0, hilo_we=0, stall=0 immediately, regardless of clk.
REQ-025 Reset during MULT or DONE SHALL abandon the sequence with no hilo_we pulse; first cycle after release behaves as IDLE.

Structure
REQ-026 Shared package alu_ctrl_pkg SHALL hold funct constants, alu_op codes, ALU sig codes, mux_sel codes and the state enumeration.
REQ-027 Combinational funct decode SHALL be one sub-module, alu_funct_decode; FSM and counter stay in alu_control_seq.

Verification
REQ-028 R-type sweep: alu_op=10, funct 32/34/36/37/42/0 -> alu_sig 010/110/000/001/111/010, mux_sel 00/00/00/00/00/01, stall=0.
REQ-029 multu at cycle 0, mfhi held valid from cycle 1 -> mult_start=1 cycle 0, stall=1 cycles 1..33, hilo_we=1 cycle 33, mux_sel=10 with stall=0 cycle 34.
REQ-030 multu at cycle 0, add at cycle 5 -> cycle 5 alu_sig=010, mux_sel=00, stall=0; busy stays 1 through cycle 33.
REQ-031 Back-to-back multu at cycles 0 and 1 -> second stalled cycles 1..33, accepted cycle 34 with mult_start=1, second hilo_we cycle 67.
REQ-032 rst pulsed at cycle 10 of a multiply -> busy=0 asynchronously, no hilo_we through cycle 40, next mflo decodes mux_sel=11, stall=0.
REQ-033 alu_op=10 funct 63, and alu_op=11 -> illegal=1, alu_sig=010, mux_sel=00, no state change.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and types for the ALU control sequencer.
package alu_ctrl_pkg;

    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned SIG_W    = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned CNT_W    = 5;

    // Main-control classes
    localparam logic [ALU_OP_W-1:0] OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] OP_RTYPE = 2'b10;
    localparam logic [ALU_OP_W-1:0] OP_ILL   = 2'b11;

    // R-type function fields
    localparam logic [FUNCT_W-1:0] F_SHIFT = 6'd0;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'd16;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'd18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'd25;
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'd32;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'd34;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'd36;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'd37;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'd42;

    // ALU operation codes
    localparam logic [SIG_W-1:0] SIG_AND = 3'b000;
    localparam logic [SIG_W-1:0] SIG_OR  = 3'b001;
    localparam logic [SIG_W-1:0] SIG_ADD = 3'b010;
    localparam logic [SIG_W-1:0] SIG_SUB = 3'b110;
    localparam logic [SIG_W-1:0] SIG_SLT = 3'b111;

    // Result source select
    localparam logic [SEL_W-1:0] SEL_ALU   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SHIFT = 2'b01;
    localparam logic [SEL_W-1:0] SEL_HI    = 2'b10;
    localparam logic [SEL_W-1:0] SEL_LO    = 2'b11;

    // Last count value of the multiply phase (32 cycles: 0..31)
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Decoded instruction payload
    typedef struct packed {
        logic [SIG_W-1:0] alu_sig;
        logic [SEL_W-1:0] mux_sel;
        logic             is_multu;
        logic             is_hilo;
        logic             illegal;
    } decode_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational main-control / funct decode into ALU and result-source controls.
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic                valid,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    output decode_t             dec
);

    // Decode the instruction class; unsupported encodings leave defaults and flag illegal
    always_comb begin
        dec          = '0;
        dec.alu_sig  = SIG_ADD;
        dec.mux_sel  = SEL_ALU;
        if (valid) begin
            case (alu_op)
                OP_ADD: dec.alu_sig = SIG_ADD;
                OP_SUB: dec.alu_sig = SIG_SUB;
                OP_RTYPE: begin
                    case (funct)
                        F_ADD:   dec.alu_sig  = SIG_ADD;
                        F_SUB:   dec.alu_sig  = SIG_SUB;
                        F_AND:   dec.alu_sig  = SIG_AND;
                        F_OR:    dec.alu_sig  = SIG_OR;
                        F_SLT:   dec.alu_sig  = SIG_SLT;
                        F_SHIFT: dec.mux_sel  = SEL_SHIFT;
                        F_MFHI: begin
                            dec.mux_sel = SEL_HI;
                            dec.is_hilo = 1'b1;
                        end
                        F_MFLO: begin
                            dec.mux_sel = SEL_LO;
                            dec.is_hilo = 1'b1;
                        end
                        F_MULTU: dec.is_multu = 1'b1;
                        default: dec.illegal  = 1'b1;
                    endcase
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control with a 32-cycle multiply sequencer and HI/LO hazard stall.
module alu_control_seq
    import alu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [SIG_W-1:0]    alu_sig,
    output logic [SEL_W-1:0]    mux_sel,
    output logic                mult_start,
    output logic                hilo_we,
    output logic                stall,
    output logic                busy,
    output logic                illegal
);

    decode_t            dec;
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               hazard;

    alu_funct_decode u_decode (
        .valid  (valid),
        .alu_op (alu_op),
        .funct  (funct),
        .dec    (dec)
    );

    // Instructions that need the multiplier or its HI/LO result
    assign hazard = dec.is_multu | dec.is_hilo;

    // State and multiply-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next state and control outputs; reset masks the pulses immediately
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        alu_sig    = dec.alu_sig;
        mux_sel    = dec.mux_sel;
        illegal    = dec.illegal;
        mult_start = 1'b0;
        hilo_we    = 1'b0;
        stall      = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dec.is_multu) begin
                    mult_start = 1'b1;
                    state_nxt  = ST_MULT;
                    count_nxt  = '0;
                end
            end
            ST_MULT: begin
                busy      = 1'b1;
                stall     = hazard;
                count_nxt = count + CNT_W'(1);
                if (count == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                hilo_we   = 1'b1;
                stall     = hazard;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase
        if (rst) begin
            mult_start = 1'b0;
            hilo_we    = 1'b0;
            stall      = 1'b0;
            busy       = 1'b0;
        end
    end

endmodule
